// File: rtl/mv_tile_engine.sv
`default_nettype none
// ============================================================================
// Module   : mv_tile_engine
// Function : y = W*x over a runtime M x K signed matrix, P rows per tile,
//            operands fetched from external BRAMs, valid/ready result stream
// Revision : 1.0  initial release
// ============================================================================
module mv_tile_engine #(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 16,
  parameter int P         = 4,
  parameter int M_MAX     = 64,
  parameter int K_MAX     = 64,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [$clog2(M_MAX+1)-1:0]   cfg_m,
  input  logic [$clog2(K_MAX+1)-1:0]   cfg_k,
  input  logic [4:0]                   cfg_shift,
  input  logic                         cfg_relu,
  output logic [$clog2(MEM_DEPTH)-1:0] weight_bram_addr,
  output logic                         weight_bram_en,
  input  logic [P*DATA_W-1:0]          weight_bram_dout,
  output logic [$clog2(MEM_DEPTH)-1:0] input_bram_addr,
  output logic                         input_bram_en,
  input  logic [DATA_W-1:0]            input_bram_dout,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic [$clog2(M_MAX)-1:0]     out_row,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);

  localparam int c_MW = $clog2(M_MAX + 1);
  localparam int c_KW = $clog2(K_MAX + 1);
  localparam int c_AW = $clog2(MEM_DEPTH);
  localparam int c_RW = $clog2(M_MAX);
  localparam int c_LW = (P > 1) ? $clog2(P) : 1;
  localparam int c_XW = $clog2(M_MAX + P + 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_FETCH = 3'd1;
  localparam logic [2:0] c_DRAIN = 3'd2;
  localparam logic [2:0] c_EMIT  = 3'd3;
  localparam logic [2:0] c_FIN   = 3'd4;

  localparam logic signed [ACC_W-1:0] c_SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_SAT_LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [2:0]             r_state, w_next;
  logic [c_MW-1:0]        r_m, w_cfg_m;
  logic [c_KW-1:0]        r_k, w_cfg_k;
  logic [4:0]             r_shift;
  logic                   r_relu;
  logic [c_KW-1:0]        r_kidx;
  logic [c_LW-1:0]        r_lane;
  logic [c_XW-1:0]        r_row_base;
  logic [c_AW-1:0]        r_wbase;
  logic                   r_vld, r_first;
  logic [P*ACC_W-1:0]     w_acc_flat;

  logic [c_XW-1:0]        w_row;
  logic                   w_row_last, w_lane_last, w_hs, w_fetch_last;
  logic signed [ACC_W-1:0] w_sel, w_shifted;
  logic signed [OUT_W-1:0] w_sat, w_result;

  assign w_cfg_m      = (cfg_m > c_MW'(M_MAX)) ? c_MW'(M_MAX) : cfg_m;
  assign w_cfg_k      = (cfg_k > c_KW'(K_MAX)) ? c_KW'(K_MAX) : cfg_k;
  assign w_row        = r_row_base + c_XW'(r_lane);
  assign w_row_last   = (w_row == (c_XW'(r_m) - c_XW'(1)));
  assign w_lane_last  = w_row_last || (r_lane == c_LW'(P - 1));
  assign w_hs         = (r_state == c_EMIT) && out_ready;
  assign w_fetch_last = (r_kidx == (r_k - c_KW'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (start) w_next = (w_cfg_m == '0 || w_cfg_k == '0) ? c_FIN : c_FETCH;
      c_FETCH: if (w_fetch_last) w_next = c_DRAIN;
      c_DRAIN: w_next = c_EMIT;
      c_EMIT:  if (w_hs && w_lane_last) w_next = w_row_last ? c_FIN : c_FETCH;
      c_FIN:   w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
    if (abort && (r_state != c_IDLE)) w_next = c_IDLE;
  end

  always_comb begin
    weight_bram_en   = 1'b0;
    input_bram_en    = 1'b0;
    weight_bram_addr = '0;
    input_bram_addr  = '0;
    out_valid        = 1'b0;
    out_data         = '0;
    out_row          = '0;
    out_last         = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    case (r_state)
      c_IDLE:  busy = 1'b0;
      c_FETCH: begin
        weight_bram_en   = 1'b1;
        input_bram_en    = 1'b1;
        weight_bram_addr = r_wbase + c_AW'(r_kidx);
        input_bram_addr  = c_AW'(r_kidx);
      end
      c_EMIT: begin
        out_valid = 1'b1;
        out_data  = w_result;
        out_row   = c_RW'(w_row);
        out_last  = w_row_last;
      end
      c_FIN:   done = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  // Job counters; only the IDLE start path initialises them, so an abort can leave them stale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m        <= '0;
      r_k        <= '0;
      r_shift    <= '0;
      r_relu     <= 1'b0;
      r_kidx     <= '0;
      r_lane     <= '0;
      r_row_base <= '0;
      r_wbase    <= '0;
    end else begin
      case (r_state)
        c_IDLE: if (start) begin
          r_m        <= w_cfg_m;
          r_k        <= w_cfg_k;
          r_shift    <= cfg_shift;
          r_relu     <= cfg_relu;
          r_kidx     <= '0;
          r_lane     <= '0;
          r_row_base <= '0;
          r_wbase    <= '0;
        end
        c_FETCH: r_kidx <= r_kidx + c_KW'(1);
        c_EMIT: if (w_hs) begin
          if (w_lane_last) begin
            r_lane     <= '0;
            r_kidx     <= '0;
            r_row_base <= r_row_base + c_XW'(P);
            r_wbase    <= r_wbase + c_AW'(r_k);
          end else begin
            r_lane <= r_lane + c_LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // BRAM data arrives one cycle after the fetch that addressed it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_first <= 1'b0;
    end else begin
      r_vld   <= (r_state == c_FETCH) && !abort;
      r_first <= (r_state == c_FETCH) && (r_kidx == '0);
    end
  end

  generate
    for (genvar j = 0; j < P; j++) begin : g_lane
      logic signed [2*DATA_W-1:0] w_prod;
      logic signed [ACC_W-1:0]    r_acc;
      assign w_prod = $signed(weight_bram_dout[j*DATA_W +: DATA_W]) * $signed(input_bram_dout);
      always_ff @(posedge clk) begin
        if (!rst_n)     r_acc <= '0;
        else if (r_vld) r_acc <= r_first ? ACC_W'(w_prod) : r_acc + ACC_W'(w_prod);
      end
      assign w_acc_flat[j*ACC_W +: ACC_W] = r_acc;
    end
  endgenerate

  always_comb begin
    w_sel     = w_acc_flat[r_lane*ACC_W +: ACC_W];
    w_shifted = w_sel >>> r_shift;
    if (w_shifted > c_SAT_HI)      w_sat = c_SAT_HI[OUT_W-1:0];
    else if (w_shifted < c_SAT_LO) w_sat = c_SAT_LO[OUT_W-1:0];
    else                           w_sat = w_shifted[OUT_W-1:0];
    w_result = (r_relu && w_sat[OUT_W-1]) ? '0 : w_sat;
  end

endmodule
`default_nettype wire

// File: tb/tb_mv_tile_engine.sv
`default_nettype none
// Testbench for mv_tile_engine: BRAM models, golden-model scoreboard, stall/abort/reset scenarios.
module tb_mv_tile_engine;
  localparam int DATA_W = 16, ACC_W = 32, OUT_W = 16, P = 4;
  localparam int M_MAX = 64, K_MAX = 64, MEM_DEPTH = 1024;
  localparam int MW = $clog2(M_MAX+1), KW = $clog2(K_MAX+1);
  localparam int AW = $clog2(MEM_DEPTH), RW = $clog2(M_MAX);

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [MW-1:0] cfg_m = '0;
  logic [KW-1:0] cfg_k = '0;
  logic [4:0]    cfg_shift = '0;
  logic          cfg_relu = 1'b0;
  logic [AW-1:0] weight_bram_addr, input_bram_addr;
  logic          weight_bram_en, input_bram_en;
  logic [P*DATA_W-1:0] weight_bram_dout = '0;
  logic [DATA_W-1:0]   input_bram_dout = '0;
  logic          out_valid, out_ready = 1'b1, out_last, busy, done;
  logic [OUT_W-1:0] out_data;
  logic [RW-1:0] out_row;

  mv_tile_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .P(P),
                   .M_MAX(M_MAX), .K_MAX(K_MAX), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .weight_bram_addr(weight_bram_addr), .weight_bram_en(weight_bram_en),
    .weight_bram_dout(weight_bram_dout),
    .input_bram_addr(input_bram_addr), .input_bram_en(input_bram_en),
    .input_bram_dout(input_bram_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .busy(busy), .done(done));

  always #5 clk = ~clk;

  logic [P*DATA_W-1:0] wmem [MEM_DEPTH];
  logic [DATA_W-1:0]   xmem [MEM_DEPTH];
  always @(posedge clk) begin
    if (weight_bram_en) weight_bram_dout <= wmem[weight_bram_addr];
    if (input_bram_en)  input_bram_dout  <= xmem[input_bram_addr];
  end

  logic signed [DATA_W-1:0] wm [M_MAX][K_MAX];
  logic signed [DATA_W-1:0] xv [K_MAX];

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [RW-1:0]    row;
    logic             last;
  } exp_t;
  exp_t sbq[$];

  int n_checks = 0, n_errors = 0;
  int hs_cnt = 0, done_cnt = 0, en_cnt = 0, first_vld_rel = -1, done_rel = -1;
  int addr_log [64];
  longint t_start = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] golden(input int row, input int k, input int sh, input bit relu);
    longint s = 0;
    longint v;
    longint hi = (longint'(1) <<< (OUT_W-1)) - 1;
    longint lo = -(longint'(1) <<< (OUT_W-1));
    logic signed [ACC_W-1:0] a;
    for (int kk = 0; kk < k; kk++) s += longint'(wm[row][kk]) * longint'(xv[kk]);
    a = s[ACC_W-1:0];
    v = longint'(a) >>> sh;
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    if (relu && v < 0) v = 0;
    return v[OUT_W-1:0];
  endfunction

  // Scoreboard consumer and event monitor, sampled mid-cycle.
  logic             held_v = 1'b0, held_l;
  logic [OUT_W-1:0] held_d;
  logic [RW-1:0]    held_r;
  always @(negedge clk) begin : mon
    int r;
    exp_t e;
    r = int'(longint'($time / 10) - t_start);
    if (out_valid && first_vld_rel < 0) first_vld_rel = r;
    if (held_v && out_valid) begin
      check("hold_data", out_data, held_d);
      check("hold_row", out_row, held_r);
      check("hold_last", out_last, held_l);
    end
    held_v = out_valid && !out_ready;
    held_d = out_data; held_r = out_row; held_l = out_last;
    if (out_valid && out_ready) begin
      hs_cnt++;
      check("sb_has_entry", longint'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("out_data", longint'($signed(out_data)), longint'($signed(e.data)));
        check("out_row", out_row, e.row);
        check("out_last", out_last, e.last);
      end
    end
    if (done) begin done_cnt++; done_rel = r; end
    if (weight_bram_en) begin
      en_cnt++;
      if (r >= 0 && r < 64) addr_log[r] = int'(weight_bram_addr);
    end
  end

  task automatic job_begin(input int m, input int k, input int sh, input bit relu);
    int mc, kc;
    exp_t e;
    mc = (m > M_MAX) ? M_MAX : m;
    kc = (k > K_MAX) ? K_MAX : k;
    for (int t = 0; t < (mc + P - 1) / P; t++)
      for (int kk = 0; kk < kc; kk++)
        for (int j = 0; j < P; j++)
          if (t*P + j < mc) wmem[t*kc + kk][j*DATA_W +: DATA_W] = wm[t*P + j][kk];
          else              wmem[t*kc + kk][j*DATA_W +: DATA_W] = DATA_W'($urandom);
    for (int kk = 0; kk < kc; kk++) xmem[kk] = xv[kk];
    if (kc > 0)
      for (int row = 0; row < mc; row++) begin
        e.data = golden(row, kc, sh, relu);
        e.row  = RW'(row);
        e.last = (row == mc - 1);
        sbq.push_back(e);
      end
    hs_cnt = 0; done_cnt = 0; en_cnt = 0; first_vld_rel = -1; done_rel = -1;
    for (int i = 0; i < 64; i++) addr_log[i] = -1;
    @(posedge clk); #1;
    cfg_m = MW'(m); cfg_k = KW'(k); cfg_shift = 5'(sh); cfg_relu = relu;
    start = 1'b1;
    t_start = longint'(($time + 4) / 10);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic job_wait(input int m, input int k, input bit timed, input bit rnd);
    int budget, tiles;
    budget = 20000;
    tiles = (k == 0) ? 0 : (m + P - 1) / P;
    while (done_cnt == 0 && budget > 0) begin
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      budget--;
    end
    check("done_seen", longint'(done_cnt > 0), 1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt, 1);
    check("busy_after", busy, 0);
    check("hs_count", hs_cnt, (k == 0) ? 0 : m);
    check("sb_empty", sbq.size(), 0);
    check("en_count", en_cnt, tiles * k);
    if (timed) begin
      check("done_cycle", done_rel, (m == 0 || k == 0) ? 1 : tiles*(k+1) + m + 1);
      if (m > 0 && k > 0) check("first_valid", first_vld_rel, k + 2);
    end
    sbq.delete();
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_en", {weight_bram_en, input_bram_en}, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // identity 4x4
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wm[r][c] = (r == c) ? 16'sd1 : 16'sd0;
    for (int c = 0; c < 4; c++) xv[c] = DATA_W'(c + 1);
    job_begin(4, 4, 0, 0);
    check("c1_busy", busy, 1);
    check("c1_wen", weight_bram_en, 1);
    check("c1_waddr", weight_bram_addr, 0);
    job_wait(4, 4, 1, 0);

    // 6x4 all 2 / all 3, with start and cfg changes while busy
    for (int r = 0; r < 6; r++) for (int c = 0; c < 4; c++) wm[r][c] = 16'sd2;
    for (int c = 0; c < 4; c++) xv[c] = 16'sd3;
    job_begin(6, 4, 0, 0);
    cfg_m = 1; cfg_k = 1; cfg_shift = 3; cfg_relu = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    job_wait(6, 4, 1, 0);
    check("t1_addr_c10", addr_log[10], 4);
    check("t1_addr_c13", addr_log[13], 7);

    // wrap + saturation
    for (int r = 0; r < 4; r++) for (int c = 0; c < 64; c++) wm[r][c] = 16'sd32767;
    for (int c = 0; c < 64; c++) xv[c] = 16'sd32767;
    job_begin(4, 64, 0, 0);  job_wait(4, 64, 1, 0);
    job_begin(4, 64, 0, 1);  job_wait(4, 64, 1, 0);
    job_begin(4, 64, 20, 0); job_wait(4, 64, 1, 0);

    // 10x7 random data with random backpressure
    for (int r = 0; r < 10; r++) for (int c = 0; c < 7; c++) wm[r][c] = DATA_W'($urandom);
    for (int c = 0; c < 7; c++) xv[c] = DATA_W'($urandom);
    job_begin(10, 7, 6, 0);
    job_wait(10, 7, 0, 1);

    // abort during tile-1 fetch, then a clean restart
    for (int r = 0; r < 8; r++) for (int c = 0; c < 5; c++) wm[r][c] = DATA_W'($urandom);
    for (int c = 0; c < 5; c++) xv[c] = DATA_W'($urandom);
    job_begin(8, 5, 2, 0);
    repeat (10) @(posedge clk);
    #1;
    check("abort_pre_addr", weight_bram_addr, 5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_en", weight_bram_en, 0);
    check("abort_hs", hs_cnt, 4);
    sbq.delete();
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 5; c++) wm[r][c] = DATA_W'($urandom);
    job_begin(8, 5, 1, 1);
    job_wait(8, 5, 1, 0);

    // empty shapes
    job_begin(0, 4, 0, 0); job_wait(0, 4, 1, 0);
    job_begin(3, 0, 0, 0); job_wait(3, 0, 1, 0);

    // reset while stalled in EMIT
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wm[r][c] = DATA_W'($urandom);
    out_ready = 1'b0;
    job_begin(4, 4, 0, 0);
    guard = 0;
    while (!out_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    check("emit_reached", out_valid, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_data", {out_data, out_row, out_last}, 0);
    check("rst_mid_busy", {busy, done}, 0);
    check("rst_mid_bram", {weight_bram_en, input_bram_en, weight_bram_addr, input_bram_addr}, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    sbq.delete();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
